// File: rtl/push_pkg.sv
// rtl/push_pkg.sv - shared types and default timing for the push-button front end
// Purpose: channel FSM state encoding, default parameter values and a small
//          helper used to size the auto-repeat counter.
// Ports:   none (package).
// Config:  PUSH_REPEAT_EN selects whether ST_REPEAT is ever reached.
package push_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_REPEAT = 2'd2
  } chan_st_t;

  localparam int unsigned DEF_CH      = 4;
  localparam int unsigned DEF_DEB_CYC = 20000;
  localparam bit          DEF_ACT_LOW = 1'b0;
  localparam int unsigned DEF_REP_DLY = 5000000;
  localparam int unsigned DEF_REP_PER = 1000000;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/push_chan.sv
// rtl/push_chan.sv - one push-button channel: sync, debounce, event FSM, auto-repeat
// Purpose: turns one raw asynchronous button into a debounced level plus
//          one-clock press/release pulses; optional auto-repeat of the press
//          pulse while the button stays down (PUSH_REPEAT_EN).
// Ports:
//   clk      in   1  clock
//   rst_n    in   1  asynchronous active-low reset
//   push     in   1  raw button (polarity set by ACT_LOW)
//   f_push   out  1  press pulse (and repeat pulses when enabled)
//   r_push   out  1  release pulse
//   level    out  1  debounced pressed level
//   hold     out  1  high while in the auto-repeat phase (0 without PUSH_REPEAT_EN)
module push_chan
  import push_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEF_DEB_CYC,
  parameter bit          ACT_LOW = DEF_ACT_LOW
`ifdef PUSH_REPEAT_EN
  ,
  parameter int unsigned REP_DLY = DEF_REP_DLY,
  parameter int unsigned REP_PER = DEF_REP_PER
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  output logic f_push,
  output logic r_push,
  output logic level,
  output logic hold
);

  localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

  logic             din;
  logic             s1, s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             press_ev, rel_ev;

  chan_st_t state, state_nx;
  logic     f_q, r_q, hold_q;
  logic     f_nx, r_nx, hold_nx;

  assign din = ACT_LOW ? ~push : push;

  // Flip only on the DEB_CYC-th consecutive cycle that s2 differs from stable.
  assign flip     = (s2 != stable) && (cnt == CNT_W'(DEB_CYC - 1));
  assign press_ev = flip & s2;
  assign rel_ev   = flip & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef PUSH_REPEAT_EN
  localparam int unsigned REP_W = $clog2(max2(REP_DLY, REP_PER) + 1);

  logic [REP_W-1:0] rep_cnt, rep_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      f_q    <= 1'b0;
      r_q    <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      state  <= state_nx;
      f_q    <= f_nx;
      r_q    <= r_nx;
      hold_q <= hold_nx;
    end
  end

  // Release takes priority over a repeat tick landing on the same edge, so
  // press and release pulses can never coincide.
  always_comb begin
    state_nx = state;
    f_nx     = 1'b0;
    r_nx     = 1'b0;
    hold_nx  = hold_q;
`ifdef PUSH_REPEAT_EN
    rep_nx   = rep_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (press_ev) begin
          state_nx = ST_PRESS;
          f_nx     = 1'b1;
`ifdef PUSH_REPEAT_EN
          rep_nx   = '0;
`endif
        end
      end
      ST_PRESS: begin
        if (rel_ev) begin
          state_nx = ST_IDLE;
          r_nx     = 1'b1;
          hold_nx  = 1'b0;
`ifdef PUSH_REPEAT_EN
          rep_nx   = '0;
        end else if (rep_cnt == REP_W'(REP_DLY - 1)) begin
          state_nx = ST_REPEAT;
          f_nx     = 1'b1;
          hold_nx  = 1'b1;
          rep_nx   = '0;
        end else begin
          rep_nx   = rep_cnt + 1'b1;
`endif
        end
      end
`ifdef PUSH_REPEAT_EN
      ST_REPEAT: begin
        if (rel_ev) begin
          state_nx = ST_IDLE;
          r_nx     = 1'b1;
          hold_nx  = 1'b0;
          rep_nx   = '0;
        end else if (rep_cnt == REP_W'(REP_PER - 1)) begin
          f_nx     = 1'b1;
          rep_nx   = '0;
        end else begin
          rep_nx   = rep_cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
        hold_nx  = 1'b0;
      end
    endcase
  end

  assign f_push = f_q;
  assign r_push = r_q;
  assign level  = stable;
`ifdef PUSH_REPEAT_EN
  assign hold   = hold_q;
`else
  assign hold   = 1'b0;
`endif

endmodule

// File: rtl/push_array_ctrl.sv
// rtl/push_array_ctrl.sv - CH-channel push-button front end built from push_chan instances
// Purpose: independent per-button sync/debounce/event generation; outputs of
//          the channels are concatenated bit-per-channel.
// Ports:
//   i_Clk    in   1   clock
//   i_Rst    in   1   asynchronous active-low reset
//   i_Push   in   CH  raw button inputs
//   o_fPush  out  CH  one-cycle press pulses (plus repeats with PUSH_REPEAT_EN)
//   o_rPush  out  CH  one-cycle release pulses
//   o_Level  out  CH  debounced pressed levels
//   o_Hold   out  CH  auto-repeat phase flags (0 without PUSH_REPEAT_EN)
// Config:  PUSH_REPEAT_EN enables auto-repeat; REP_DLY/REP_PER are ignored otherwise.
module push_array_ctrl
  import push_pkg::*;
#(
  parameter int unsigned CH      = DEF_CH,
  parameter int unsigned DEB_CYC = DEF_DEB_CYC,
  parameter bit          ACT_LOW = DEF_ACT_LOW,
  parameter int unsigned REP_DLY = DEF_REP_DLY,
  parameter int unsigned REP_PER = DEF_REP_PER
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [CH-1:0] i_Push,
  output logic [CH-1:0] o_fPush,
  output logic [CH-1:0] o_rPush,
  output logic [CH-1:0] o_Level,
  output logic [CH-1:0] o_Hold
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    push_chan #(
      .DEB_CYC (DEB_CYC),
      .ACT_LOW (ACT_LOW)
`ifdef PUSH_REPEAT_EN
      ,
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
`endif
    ) u_chan (
      .clk    (i_Clk),
      .rst_n  (i_Rst),
      .push   (i_Push[g]),
      .f_push (o_fPush[g]),
      .r_push (o_rPush[g]),
      .level  (o_Level[g]),
      .hold   (o_Hold[g])
    );
  end

endmodule

// File: tb/tb_push_array_ctrl.sv
// tb/tb_push_array_ctrl.sv - directed self-checking bench for push_array_ctrl
module tb_push_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] push;
  logic [3:0] fpush, rpush, level, hold;

  int n_checks = 0;
  int n_fail   = 0;

  push_array_ctrl #(
    .CH      (4),
    .DEB_CYC (4),
    .ACT_LOW (1'b0),
    .REP_DLY (20),
    .REP_PER (8)
  ) dut (
    .i_Clk   (clk),
    .i_Rst   (rst_n),
    .i_Push  (push),
    .o_fPush (fpush),
    .o_rPush (rpush),
    .o_Level (level),
    .o_Hold  (hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: returns 1 time unit after the rising edge, so cycle k means
  // "sampled after the k-th edge since the stimulus was applied".
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push  = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ef, er, eh;

    rst_n = 1'b1;
    push  = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("rst_fpush", fpush, 4'b0000);
    check("rst_rpush", rpush, 4'b0000);
    check("rst_level", level, 4'b0000);
    check("rst_hold",  hold,  4'b0000);
    step();
    step();
    rst_n = 1'b1;

    // 1: held press on ch0, pulse at cycle DEB_CYC+2 = 6
    push = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t1_fpush_c%0d", k), fpush, (k == 6) ? 4'b0001 : 4'b0000);
      check($sformatf("t1_level_c%0d", k), level, (k >= 6) ? 4'b0001 : 4'b0000);
    end

    // 2: 3-cycle glitch on ch1 is one short of DEB_CYC and must vanish
    do_reset();
    push = 4'b0010;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) push = 4'b0000;
      check($sformatf("t2_fpush_c%0d", k), fpush, 4'b0000);
      check($sformatf("t2_level_c%0d", k), level, 4'b0000);
    end

    // 3: release after 20 cycles held, release pulse 6 cycles later
    do_reset();
    push = 4'b0100;
    repeat (20) step();
    check("t3_level_held", level, 4'b0100);
    push = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t3_rpush_c%0d", k), rpush, (k == 6) ? 4'b0100 : 4'b0000);
      check($sformatf("t3_fpush_c%0d", k), fpush, 4'b0000);
      check($sformatf("t3_level_c%0d", k), level, (k < 6) ? 4'b0100 : 4'b0000);
    end

    // 4: all channels at once
    do_reset();
    push = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t4_fpush_c%0d", k), fpush, (k == 6) ? 4'b1111 : 4'b0000);
    end

    // 5: async reset with ch1 pressed and ch0 mid-debounce (cnt=2)
    do_reset();
    push = 4'b0010;
    repeat (8) step();
    check("t5_level_pre", level, 4'b0010);
    push = 4'b0011;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("t5_level_rst", level, 4'b0000);
    check("t5_fpush_rst", fpush, 4'b0000);
    check("t5_rpush_rst", rpush, 4'b0000);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("t5_fpush_c%0d", k), fpush, (k == 6) ? 4'b0011 : 4'b0000);
      check($sformatf("t5_level_c%0d", k), level, (k >= 6) ? 4'b0011 : 4'b0000);
      check($sformatf("t5_rpush_c%0d", k), rpush, 4'b0000);
    end

    // 6: ch3 held 60 cycles, auto-repeat when built in
    do_reset();
    push = 4'b1000;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 60) push = 4'b0000;
`ifdef PUSH_REPEAT_EN
      ef = (k == 6 || k == 26 || k == 34 || k == 42 || k == 50 || k == 58) ? 4'b1000 : 4'b0000;
      eh = (k >= 26 && k < 66) ? 4'b1000 : 4'b0000;
`else
      ef = (k == 6) ? 4'b1000 : 4'b0000;
      eh = 4'b0000;
`endif
      er = (k == 66) ? 4'b1000 : 4'b0000;
      check($sformatf("t6_fpush_c%0d", k), fpush, ef);
      check($sformatf("t6_hold_c%0d", k),  hold,  eh);
      check($sformatf("t6_rpush_c%0d", k), rpush, er);
      check($sformatf("t6_overlap_c%0d", k), fpush & rpush, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
